// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared FSM state type and index-width helper for stream_arbiter.
package stream_arb_pkg;

  typedef enum logic {IDLE, XFER} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted request strictly after last_grant.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             any,
  output logic [IW-1:0]    idx
);

  int c;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    any = |req;
    idx = '0;
    c   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = (int'(last_grant) + k) % N_REQ;
      if (req[c]) idx = IW'(c);
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin frame arbiter feeding the Adler-32 core's byte stream.
// Optional idle watchdog enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  localparam int IW     = idx_w(N_REQ)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic                   out_start,
  input  logic                   out_ready,
  output logic [IW-1:0]          grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 2) begin : g_bad_param
    $error("stream_arbiter: parameter out of range");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic          first_q, first_d;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          tout_d;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  assign busy      = state_q == XFER;
  assign grant_id  = grant_q;
  assign out_valid = busy & req_valid[grant_q];
  assign out_data  = busy ? req_data[grant_q*WIDTH +: WIDTH] : '0;
  assign out_last  = busy & req_last[grant_q];
  assign out_start = first_q & out_valid;
  assign req_ready = (busy && out_ready) ? N_REQ'(1) << grant_q : '0;

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q;
  // A stalled beat keeps req_valid high, so back-pressure never advances the count.
  always_comb begin
    cnt_d  = (busy && !req_valid[grant_q]) ? cnt_q + 1'b1 : '0;
    tout_d = busy && !req_valid[grant_q] && (cnt_q == CW'(TIMEOUT - 1));
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= tout_d ? '0 : cnt_d;
      tout_q <= tout_d;
    end
  end
  assign timeout_err = tout_q;
`else
  assign tout_d      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    first_d = first_q;
    if (state_q == IDLE) begin
      if (pick_any) begin
        state_d = XFER;
        grant_d = pick_idx;
        last_d  = pick_idx;
        first_d = 1'b1;
      end
    end else if (tout_d) begin
      state_d = IDLE;
    end else if (out_valid && out_ready) begin
      first_d = 1'b0;
      state_d = out_last ? IDLE : XFER;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

endmodule
